// File: rtl/layer_1_5_sequencer_if.sv
// Pixel stream, weight ROM, multiplier and result port of the layer-1.5 sequencer.
// master = sequencer side, slave = the surrounding pixel source / ROM / multiplier / consumer.
interface layer_1_5_sequencer_if #(
    parameter int SIZE        = 8,
    parameter int OUTPUT_SIZE = 16,
    parameter int ADDR_WIDTH  = 8
);
    logic                   pixel_bit;
    logic                   pixel_valid;
    logic                   pixel_ready;
    logic [ADDR_WIDTH-1:0]  weight_addr;
    logic [SIZE-1:0]        weight_data_1, weight_data_2, weight_data_3, weight_data_4, weight_data_5;
    logic [SIZE-1:0]        vector_output_1, vector_output_2, vector_output_3, vector_output_4, vector_output_5;
    logic                   mask_output;
    logic                   load;
    logic                   accumulate;
    logic                   mult_reset;
    logic [OUTPUT_SIZE-1:0] accumulate_1, accumulate_2, accumulate_3, accumulate_4, accumulate_5;
    logic [OUTPUT_SIZE-1:0] result_1, result_2, result_3, result_4, result_5;
    logic                   result_valid;
    logic                   result_ready;

    modport master (
        input  pixel_bit, pixel_valid,
        output pixel_ready,
        output weight_addr,
        input  weight_data_1, weight_data_2, weight_data_3, weight_data_4, weight_data_5,
        output vector_output_1, vector_output_2, vector_output_3, vector_output_4, vector_output_5,
        output mask_output, load, accumulate, mult_reset,
        input  accumulate_1, accumulate_2, accumulate_3, accumulate_4, accumulate_5,
        output result_1, result_2, result_3, result_4, result_5,
        output result_valid,
        input  result_ready
    );

    modport slave (
        output pixel_bit, pixel_valid,
        input  pixel_ready,
        input  weight_addr,
        output weight_data_1, weight_data_2, weight_data_3, weight_data_4, weight_data_5,
        input  vector_output_1, vector_output_2, vector_output_3, vector_output_4, vector_output_5,
        input  mask_output, load, accumulate, mult_reset,
        output accumulate_1, accumulate_2, accumulate_3, accumulate_4, accumulate_5,
        input  result_1, result_2, result_3, result_4, result_5,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/layer_1_5_sequencer.sv
// Feeds one image through the five-lane masked multiply/accumulate; >=2 cycles per element, results 3 cycles after the last pixel.
// Waits on pixel_valid low per element; results held stable until result_ready.
module layer_1_5_sequencer #(
    parameter int SIZE        = 8,
    parameter int OUTPUT_SIZE = 16,
    parameter int NUM_INPUTS  = 256,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    layer_1_5_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT_PIX, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_INPUTS - 1);

    state_t                 state, state_d;
    logic [ADDR_WIDTH-1:0]  index, index_d;
    logic [1:0]             drain_cnt, drain_d;
    logic                   busy_q, busy_d;
    logic                   pix_rdy_q, pix_rdy_d;
    logic                   load_q, load_d;
    logic                   mrst_q, mrst_d;
    logic                   mask_q, mask_d;
    logic                   rv_q, rv_d;
    logic [SIZE-1:0]        vec_q [1:5];
    logic [SIZE-1:0]        vec_d [1:5];
    logic [OUTPUT_SIZE-1:0] res_q [1:5];
    logic [OUTPUT_SIZE-1:0] res_d [1:5];
    logic [SIZE-1:0]        wdat  [1:5];
    logic [OUTPUT_SIZE-1:0] acc   [1:5];

    assign wdat[1] = bus.weight_data_1;
    assign wdat[2] = bus.weight_data_2;
    assign wdat[3] = bus.weight_data_3;
    assign wdat[4] = bus.weight_data_4;
    assign wdat[5] = bus.weight_data_5;
    assign acc[1]  = bus.accumulate_1;
    assign acc[2]  = bus.accumulate_2;
    assign acc[3]  = bus.accumulate_3;
    assign acc[4]  = bus.accumulate_4;
    assign acc[5]  = bus.accumulate_5;

    always_comb begin
        state_d   = state;
        index_d   = index;
        drain_d   = drain_cnt;
        busy_d    = busy_q;
        pix_rdy_d = pix_rdy_q;
        load_d    = 1'b0;
        mrst_d    = 1'b0;
        mask_d    = mask_q;
        rv_d      = rv_q;
        vec_d     = vec_q;
        res_d     = res_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    mrst_d  = 1'b1;
                    index_d = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: state_d = FETCH;
            FETCH: begin
                // weight_addr has been stable for a cycle, so ROM data is valid in WAIT_PIX
                state_d   = WAIT_PIX;
                pix_rdy_d = 1'b1;
            end
            WAIT_PIX: begin
                if (bus.pixel_valid && pix_rdy_q) begin
                    load_d    = 1'b1;
                    mask_d    = bus.pixel_bit;
                    vec_d     = wdat;
                    pix_rdy_d = 1'b0;
                    if (index == LAST) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        index_d = index + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                // load cycle, multiplier input register, accumulator update
                if (drain_cnt == 2'd2) begin
                    res_d   = acc;
                    rv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    drain_d = drain_cnt + 2'd1;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    rv_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            pix_rdy_q <= 1'b0;
            load_q    <= 1'b0;
            mrst_q    <= 1'b0;
            mask_q    <= 1'b0;
            rv_q      <= 1'b0;
            vec_q     <= '{default: '0};
            res_q     <= '{default: '0};
        end else begin
            state     <= state_d;
            index     <= index_d;
            drain_cnt <= drain_d;
            busy_q    <= busy_d;
            pix_rdy_q <= pix_rdy_d;
            load_q    <= load_d;
            mrst_q    <= mrst_d;
            mask_q    <= mask_d;
            rv_q      <= rv_d;
            vec_q     <= vec_d;
            res_q     <= res_d;
        end
    end

    assign busy                = busy_q;
    assign bus.pixel_ready     = pix_rdy_q;
    assign bus.weight_addr     = index;
    assign bus.load            = load_q;
    assign bus.accumulate      = load_q;
    assign bus.mult_reset      = mrst_q;
    assign bus.mask_output     = mask_q;
    assign bus.result_valid    = rv_q;
    assign bus.vector_output_1 = vec_q[1];
    assign bus.vector_output_2 = vec_q[2];
    assign bus.vector_output_3 = vec_q[3];
    assign bus.vector_output_4 = vec_q[4];
    assign bus.vector_output_5 = vec_q[5];
    assign bus.result_1        = res_q[1];
    assign bus.result_2        = res_q[2];
    assign bus.result_3        = res_q[3];
    assign bus.result_4        = res_q[4];
    assign bus.result_5        = res_q[5];
endmodule

// File: tb/tb_layer_1_5_sequencer.sv
// Bench for layer_1_5_sequencer with NUM_INPUTS=4, a registered weight ROM (lane n = addr+n)
// and a two-stage x16 masked multiply/accumulate model.
module tb_layer_1_5_sequencer;
    // element i is bit i: A = pixels 1,0,1,1 ; B = pixels 0,1,1,0
    localparam logic [3:0]  PIX_A = 4'b1101;
    localparam logic [3:0]  PIX_B = 4'b0110;
    // lane n of A: (0+n + 2+n + 3+n)*16 ; lane n of B: (1+n + 2+n)*16
    localparam logic [79:0] EXP_A = {16'd320, 16'd272, 16'd224, 16'd176, 16'd128};
    localparam logic [79:0] EXP_B = {16'd208, 16'd176, 16'd144, 16'd112, 16'd80};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy;

    int total = 0;
    int bad = 0;
    int pcyc = 0;
    int hs_pcyc = 0;
    int load_cnt = 0;
    int mrst_cnt = 0;
    logic [79:0] res_q [$];
    logic [8:0]  ld_q  [$];

    layer_1_5_sequencer_if #(.SIZE(8), .OUTPUT_SIZE(16), .ADDR_WIDTH(8)) bus ();

    layer_1_5_sequencer #(.SIZE(8), .OUTPUT_SIZE(16), .NUM_INPUTS(4), .ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    logic [7:0]  vo   [1:5];
    logic [7:0]  rom  [1:5] = '{default: 8'd0};
    logic [15:0] prod [1:5] = '{default: 16'd0};
    logic [15:0] macc [1:5] = '{default: 16'd0};
    logic        pv = 1'b0;
    logic [79:0] res_all;

    assign vo[1] = bus.vector_output_1;
    assign vo[2] = bus.vector_output_2;
    assign vo[3] = bus.vector_output_3;
    assign vo[4] = bus.vector_output_4;
    assign vo[5] = bus.vector_output_5;
    assign bus.weight_data_1 = rom[1];
    assign bus.weight_data_2 = rom[2];
    assign bus.weight_data_3 = rom[3];
    assign bus.weight_data_4 = rom[4];
    assign bus.weight_data_5 = rom[5];
    assign bus.accumulate_1 = macc[1];
    assign bus.accumulate_2 = macc[2];
    assign bus.accumulate_3 = macc[3];
    assign bus.accumulate_4 = macc[4];
    assign bus.accumulate_5 = macc[5];
    assign res_all = {bus.result_5, bus.result_4, bus.result_3, bus.result_2, bus.result_1};

    always @(posedge clk) begin
        pv <= bus.load && bus.accumulate;
        for (int n = 1; n <= 5; n++) begin
            rom[n]  <= bus.weight_addr + 8'(n);
            prod[n] <= bus.mask_output ? {4'b0, vo[n], 4'b0} : 16'd0;
            if (bus.mult_reset) macc[n] <= 16'd0;
            else if (pv)        macc[n] <= macc[n] + prod[n];
        end
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, " ctl"}, {busy, bus.load, bus.accumulate, bus.mult_reset, bus.mask_output,
                             bus.pixel_ready, bus.result_valid}, 0);
        chk({name, " addr"}, bus.weight_addr, 0);
        chk({name, " vec"}, {vo[1], vo[2], vo[3], vo[4], vo[5]}, 0);
        chk({name, " res"}, res_all, 0);
    endtask

    // monitor / scoreboard
    initial begin
        logic prev_rv;
        logic [8:0] e;
        logic [79:0] r;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.load) begin
                load_cnt++;
                if (ld_q.size() == 0) chk("unexpected load", 1, 0);
                else begin
                    e = ld_q.pop_front();
                    chk("load accumulate", bus.accumulate, 1);
                    chk("load mask", bus.mask_output, e[0]);
                    for (int n = 1; n <= 5; n++) chk("load vector", vo[n], 8'(e[8:1] + 8'(n)));
                end
            end
            if (bus.mult_reset) mrst_cnt++;
            if (bus.result_valid && !prev_rv) chk("result latency", pcyc - hs_pcyc, 3);
            prev_rv = bus.result_valid;
            if (bus.result_valid && bus.result_ready) begin
                if (res_q.size() == 0) chk("unexpected result", 1, 0);
                else begin
                    r = res_q.pop_front();
                    for (int n = 0; n < 5; n++) chk("result lane", res_all[n*16 +: 16], r[n*16 +: 16]);
                end
            end
        end
    end

    task automatic run_image(input logic [3:0] pix, input bit stall, input int n_elems,
                             input logic [79:0] exp_res, input bit expect_res);
        int to;
        if (expect_res) res_q.push_back(exp_res);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy after start", busy, 1);
        chk("mult_reset after start", bus.mult_reset, 1);
        for (int i = 0; i < n_elems; i++) begin
            if (stall) begin
                bus.pixel_valid = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k >= 1) begin
                        chk("stall no load", bus.load, 0);
                        chk("stall addr", bus.weight_addr, i);
                        if (i > 0) chk("stall vector", vo[1], i);
                    end
                    @(posedge clk); #1;
                end
            end
            bus.pixel_valid = 1'b1;
            bus.pixel_bit   = pix[i];
            to = 0;
            do begin @(negedge clk); to++; end while (!bus.pixel_ready && to < 50);
            if (!bus.pixel_ready) begin
                chk("pixel handshake timeout", 0, 1);
                bus.pixel_valid = 1'b0;
                return;
            end
            chk("addr at handshake", bus.weight_addr, i);
            ld_q.push_back({8'(i), pix[i]});
            @(posedge clk); #1;
            hs_pcyc = pcyc;
            bus.pixel_valid = 1'b0;
        end
    endtask

    task automatic wait_result();
        int to;
        to = 0;
        do begin @(negedge clk); to++; end while (!bus.result_valid && to < 100);
        chk("result_valid within budget", bus.result_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, m0;
        bus.pixel_valid  = 1'b0;
        bus.pixel_bit    = 1'b0;
        bus.result_ready = 1'b1;

        // reset and quiet idle
        #1 reset = 1'b1;
        #1 check_zero("reset");
        @(negedge clk); #2 reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle quiet", {busy, bus.load, bus.mult_reset, bus.pixel_ready, bus.result_valid, bus.weight_addr}, 0);
        end

        // single image, no stalls
        l0 = load_cnt; m0 = mrst_cnt;
        run_image(PIX_A, 1'b0, 4, EXP_A, 1'b1);
        wait_result();
        chk("result_1 image A", bus.result_1, 128);
        @(posedge clk); #1;
        chk("busy after result", busy, 0);
        chk("load pulses A", load_cnt - l0, 4);
        chk("mult_reset pulses A", mrst_cnt - m0, 1);

        // pixel backpressure
        l0 = load_cnt;
        run_image(PIX_A, 1'b1, 4, EXP_A, 1'b1);
        wait_result();
        @(posedge clk); #1;
        chk("load pulses stalled", load_cnt - l0, 4);

        // result backpressure with start pulsed during DONE
        bus.result_ready = 1'b0;
        run_image(PIX_B, 1'b0, 4, EXP_B, 1'b1);
        wait_result();
        m0 = mrst_cnt;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1 start = (k == 4);
            @(negedge clk);
            chk("held valid", bus.result_valid, 1);
            chk("held results", res_all, EXP_B);
            chk("held busy", busy, 1);
        end
        @(posedge clk); #1;
        start = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("idle after handshake", busy, 0);
        chk("valid dropped", bus.result_valid, 0);
        chk("results kept", res_all, EXP_B);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("start in DONE ignored", {busy, bus.mult_reset}, 0);
        end
        chk("no mult_reset from ignored start", mrst_cnt - m0, 0);

        // reset after 2 of 4 elements
        run_image(PIX_A, 1'b0, 2, 80'd0, 1'b0);
        @(negedge clk); #2 reset = 1'b1;
        #1 check_zero("abort reset");
        @(negedge clk); #2 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no result after abort", bus.result_valid, 0);
        end
        chk("loads drained after abort", ld_q.size(), 0);
        m0 = mrst_cnt;
        run_image(PIX_A, 1'b0, 4, EXP_A, 1'b1);
        wait_result();
        @(posedge clk); #1;
        chk("mult_reset after abort", mrst_cnt - m0, 1);

        // back-to-back images
        m0 = mrst_cnt;
        run_image(PIX_B, 1'b0, 4, EXP_B, 1'b1);
        wait_result();
        run_image(PIX_A, 1'b0, 4, EXP_A, 1'b1);
        wait_result();
        @(posedge clk); #1;
        chk("mult_reset back-to-back", mrst_cnt - m0, 2);
        repeat (3) @(negedge clk);
        chk("result queue empty", res_q.size(), 0);
        chk("load queue empty", ld_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
